// File: rtl/simmem_pkg.sv
// Shared types and defaults for the simulated-memory write-response release logic.
package simmem_pkg;

    localparam int unsigned RelIdWidth    = 4;
    localparam int unsigned RelNumSlots   = 8;
    localparam int unsigned RelDelayWidth = 6;

    // One outstanding delay entry; cnt == 0 with valid set means released.
    typedef struct packed {
        logic                     valid;
        logic [RelIdWidth-1:0]    id;
        logic [RelDelayWidth-1:0] cnt;
    } releaser_slot_t;

endpackage

// File: rtl/simmem_lowest_one.sv
// Priority encoder: one-hot of the lowest set request bit, plus an any-set flag.
module simmem_lowest_one #(
    parameter int unsigned NumSlots = 8
) (
    input  logic [NumSlots-1:0] req,
    output logic [NumSlots-1:0] onehot,
    output logic                any
);

    // Scanning downwards lets the lowest set bit overwrite any higher one.
    always_comb begin
        onehot = '0;
        for (int i = NumSlots - 1; i >= 0; i--) begin
            if (req[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/simmem_write_resp_releaser.sv
// Holds per-burst delay entries and raises release_en per AXI ID once an entry of that ID expires.
module simmem_write_resp_releaser
    import simmem_pkg::*;
#(
    parameter int unsigned IDWidth    = RelIdWidth,
    parameter int unsigned NumSlots   = RelNumSlots,
    parameter int unsigned DelayWidth = RelDelayWidth
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [IDWidth-1:0]      req_id_i,
    input  logic [DelayWidth-1:0]   req_delay_i,
    output logic [2**IDWidth-1:0]   release_en_o,
    input  logic                    done_valid_i,
    input  logic [IDWidth-1:0]      done_id_i,
    output logic                    spurious_o
);

    localparam logic [DelayWidth-1:0] CntOne = 1;

    releaser_slot_t slots [NumSlots];

    logic [NumSlots-1:0] free_vec;
    logic [NumSlots-1:0] expired_vec;
    logic [NumSlots-1:0] match_vec;
    logic [NumSlots-1:0] alloc_oh;
    logic [NumSlots-1:0] match_oh;
    logic [NumSlots-1:0] retire_oh;
    logic                any_free;
    logic                any_match;
    logic                accept;

    always_comb begin
        for (int i = 0; i < NumSlots; i++) begin
            free_vec[i]    = ~slots[i].valid;
            expired_vec[i] = slots[i].valid && (slots[i].cnt == '0);
            match_vec[i]   = expired_vec[i] && (slots[i].id == done_id_i);
        end
    end

    simmem_lowest_one #(.NumSlots(NumSlots)) u_alloc (
        .req    (free_vec),
        .onehot (alloc_oh),
        .any    (any_free)
    );

    simmem_lowest_one #(.NumSlots(NumSlots)) u_retire (
        .req    (match_vec),
        .onehot (match_oh),
        .any    (any_match)
    );

    assign req_ready_o = any_free;
    assign accept      = req_valid_i && any_free;
    assign retire_oh   = match_oh & {NumSlots{done_valid_i}};

    // Only registered state feeds release_en, so the bank never sees a req/done path.
    always_comb begin
        release_en_o = '0;
        for (int i = 0; i < NumSlots; i++) begin
            if (expired_vec[i]) begin
                release_en_o[slots[i].id] = 1'b1;
            end
        end
    end

    // A retired slot is expired, hence never also the allocation target this cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumSlots; i++) begin
                slots[i] <= '0;
            end
            spurious_o <= 1'b0;
        end else begin
            for (int i = 0; i < NumSlots; i++) begin
                if (retire_oh[i]) begin
                    slots[i].valid <= 1'b0;
                end else if (accept && alloc_oh[i]) begin
                    slots[i].valid <= 1'b1;
                    slots[i].id    <= req_id_i;
                    slots[i].cnt   <= req_delay_i;
                end else if (slots[i].valid && (slots[i].cnt != '0)) begin
                    slots[i].cnt <= slots[i].cnt - CntOne;
                end
            end
            spurious_o <= done_valid_i && !any_match;
        end
    end

endmodule

// File: tb/tb_simmem_write_resp_releaser.sv
// Directed and random stimulus against a release-time reference model of the write-response releaser.
module tb_simmem_write_resp_releaser;

    localparam int NS = 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [3:0]  req_id_i;
    logic [5:0]  req_delay_i;
    logic [15:0] release_en_o;
    logic        done_valid_i;
    logic [3:0]  done_id_i;
    logic        spurious_o;

    simmem_write_resp_releaser dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_id_i     (req_id_i),
        .req_delay_i  (req_delay_i),
        .release_en_o (release_en_o),
        .done_valid_i (done_valid_i),
        .done_id_i    (done_id_i),
        .spurious_o   (spurious_o)
    );

    always #5 clk_i = ~clk_i;

    // Model: each outstanding entry is an ID plus the absolute cycle it becomes released.
    int          q_id[$];
    int          q_rel[$];
    int          cyc = 0;
    logic        exp_spur = 1'b0;
    bit          last_acc;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit rv, input int rid, input int rd,
                        input bit dv, input int did, input bit check);
        logic [15:0] exp_rel;
        bit          ready_pre;
        int          hit;
        rst_i        = r;
        req_valid_i  = rv;
        req_id_i     = rid[3:0];
        req_delay_i  = rd[5:0];
        done_valid_i = dv;
        done_id_i    = did[3:0];
        @(negedge clk_i);
        exp_rel = '0;
        foreach (q_id[k]) if (q_rel[k] <= cyc) exp_rel[q_id[k]] = 1'b1;
        ready_pre = (q_id.size() < NS);
        if (check) begin
            chk("release_en", {16'h0, release_en_o}, {16'h0, exp_rel});
            chk("req_ready", {31'h0, req_ready_o}, {31'h0, ready_pre});
            chk("spurious", {31'h0, spurious_o}, {31'h0, exp_spur});
        end
        @(posedge clk_i);
        last_acc = 1'b0;
        if (r) begin
            q_id.delete();
            q_rel.delete();
            exp_spur = 1'b0;
        end else begin
            hit = -1;
            if (dv) foreach (q_id[k]) if (hit < 0 && q_id[k] == did && q_rel[k] <= cyc) hit = k;
            exp_spur = dv && (hit < 0);
            if (hit >= 0) begin
                q_id.delete(hit);
                q_rel.delete(hit);
            end
            if (rv && ready_pre) begin
                q_id.push_back(rid);
                q_rel.push_back(cyc + 1 + rd);
                last_acc = 1'b1;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        int acc_at;
        bit hv;
        int hid, hd;
        rst_i = 1'b1; req_valid_i = 1'b0; req_id_i = '0; req_delay_i = '0;
        done_valid_i = 1'b0; done_id_i = '0;

        // Reset from unknown state, then check post-reset outputs.
        step(1, 0, 0, 0, 0, 0, 0);
        idle(1);

        // id 3, delay 5: release at T+6, done at T+8.
        step(0, 1, 3, 5, 0, 0, 1);
        idle(7);
        step(0, 0, 0, 0, 1, 3, 1);
        idle(2);

        // Two zero-delay entries on id 0 need two dones.
        do_reset();
        step(0, 1, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 0, 1);
        idle(1);
        step(0, 0, 0, 0, 1, 0, 1);
        idle(2);

        // Fill the table, hold a ninth request, retire slot 0 after it expires.
        do_reset();
        for (int k = 0; k < NS; k++) step(0, 1, k, 63, 0, 0, 1);
        acc_at = -1;
        for (int i = 0; i < 70; i++) begin
            step(0, 1, 9, 3, (i == 56), 0, 1);
            if (last_acc) begin
                acc_at = i;
                break;
            end
        end
        chk("ninth_accept_cycle", acc_at, 57);
        idle(5);

        // Done for an ID with nothing expired.
        do_reset();
        step(0, 1, 1, 0, 0, 0, 1);
        idle(1);
        step(0, 0, 0, 0, 1, 7, 1);
        idle(2);

        // Accept and done on the same ID in one cycle.
        do_reset();
        step(0, 1, 2, 0, 0, 0, 1);
        idle(1);
        step(0, 1, 2, 4, 1, 2, 1);
        idle(6);
        step(0, 0, 0, 0, 1, 2, 1);
        idle(2);

        // Reset mid-countdown with a request pending.
        do_reset();
        for (int k = 0; k < 4; k++) step(0, 1, k + 4, 20, 0, 0, 1);
        idle(3);
        step(1, 1, 5, 1, 1, 4, 1);
        idle(25);

        // Random traffic; a held request keeps its fields until accepted.
        do_reset();
        hv = 1'b0; hid = 0; hd = 0;
        for (int i = 0; i < 500; i++) begin
            if (!hv || last_acc) begin
                hv  = ($urandom_range(0, 1) == 1);
                hid = $urandom_range(0, 3);
                hd  = $urandom_range(0, 12);
            end
            step(0, hv, hid, hd, ($urandom_range(0, 9) < 4), $urandom_range(0, 3), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
